// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_controller
// Purpose  : Sequencing controller for the pipelined MIPS datapath. Decides
//            each cycle which pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB)
//            and the PC advance, hold or flush. It also inserts load-use
//            bubbles, drains the pipeline on halt and counts stall cycles.
// Ports    : CLK, nRST             clock, asynchronous active-low reset
//            ihit, dhit, mem_req   cache handshake
//            hazard_dec/ex         load-use bubble requests (2 / 1 bubbles)
//            branch_ex, halt_mem   taken branch in EX, halt in MEM
//            pc_en, *_en, *_flush  latch control (combinational)
//            halt                  sticky halted flag
//            stall_count           RUN cycles with pc_en low (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_controller #(
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_req,
    input  logic            hazard_dec,
    input  logic            hazard_ex,
    input  logic            branch_ex,
    input  logic            halt_mem,
    output logic            pc_en,
    output logic            fd_en,
    output logic            de_en,
    output logic            em_en,
    output logic            mw_en,
    output logic            fd_flush,
    output logic            de_flush,
    output logic            em_flush,
    output logic            halt,
    output logic [CNTW-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [1:0]  bub_cnt, bub_cnt_next;
    logic        advance;

    // Ungated control; the outputs are forced low while reset is asserted.
    logic pc_c, fd_c, de_c, em_c, mw_c, fdf_c, def_c, emf_c;

    assign advance = ihit & ~(mem_req & ~dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            bub_cnt     <= 2'd0;
            stall_count <= '0;
        end else begin
            state   <= state_next;
            bub_cnt <= bub_cnt_next;
            if ((state == RUN) && !pc_c && (stall_count != {CNTW{1'b1}}))
                stall_count <= stall_count + CNTW'(1);
        end
    end

    always_comb begin
        state_next   = state;
        bub_cnt_next = bub_cnt;
        pc_c  = 1'b0;
        fd_c  = 1'b0;
        de_c  = 1'b0;
        em_c  = 1'b0;
        mw_c  = 1'b0;
        fdf_c = 1'b0;
        def_c = 1'b0;
        emf_c = 1'b0;
        unique case (state)
            RUN: begin
                if (!advance) begin
                    // Memory op finished while fetch still waits: retire it and
                    // clear EX/MEM so the access is not issued a second time.
                    if (dhit && !ihit) begin
                        mw_c  = 1'b1;
                        em_c  = 1'b1;
                        emf_c = 1'b1;
                    end
                end else if (halt_mem) begin
                    fd_c  = 1'b1;
                    de_c  = 1'b1;
                    em_c  = 1'b1;
                    mw_c  = 1'b1;
                    fdf_c = 1'b1;
                    def_c = 1'b1;
                    emf_c = 1'b1;
                    state_next   = DRAIN;
                    bub_cnt_next = 2'd0;
                end else if (branch_ex) begin
                    // Wrong-path squash also cancels any pending bubble.
                    pc_c  = 1'b1;
                    fd_c  = 1'b1;
                    de_c  = 1'b1;
                    em_c  = 1'b1;
                    mw_c  = 1'b1;
                    fdf_c = 1'b1;
                    def_c = 1'b1;
                    bub_cnt_next = 2'd0;
                end else if ((bub_cnt != 2'd0) || hazard_dec || hazard_ex) begin
                    de_c  = 1'b1;
                    def_c = 1'b1;
                    em_c  = 1'b1;
                    mw_c  = 1'b1;
                    // bub_cnt counts bubbles still owed after this one.
                    if (bub_cnt != 2'd0)
                        bub_cnt_next = bub_cnt - 2'd1;
                    else if (hazard_dec)
                        bub_cnt_next = 2'd1;
                    else
                        bub_cnt_next = 2'd0;
                end else begin
                    pc_c = 1'b1;
                    fd_c = 1'b1;
                    de_c = 1'b1;
                    em_c = 1'b1;
                    mw_c = 1'b1;
                end
            end
            DRAIN: begin
                mw_c       = 1'b1;
                state_next = HALTED;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign pc_en    = pc_c  & nRST;
    assign fd_en    = fd_c  & nRST;
    assign de_en    = de_c  & nRST;
    assign em_en    = em_c  & nRST;
    assign mw_en    = mw_c  & nRST;
    assign fd_flush = fdf_c & nRST;
    assign de_flush = def_c & nRST;
    assign em_flush = emf_c & nRST;
    assign halt     = (state == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_controller
// Purpose  : Directed self-checking bench for pipeline_controller. Expected
//            control vectors are queued when stimulus is applied and popped
//            for comparison mid-cycle. A second instance with a 2-bit
//            counter exercises stall_count saturation on the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    logic CLK = 1'b0;
    logic nRST;
    logic ihit, dhit, mem_req, hazard_dec, hazard_ex, branch_ex, halt_mem;
    logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halt;
    logic [31:0] stall_count;
    logic pc_en2, fd_en2, de_en2, em_en2, mw_en2, fdf2, def2, emf2, halt2;
    logic [1:0]  stall_sat;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pipeline_controller #(.CNTW(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .hazard_dec(hazard_dec), .hazard_ex(hazard_ex), .branch_ex(branch_ex),
        .halt_mem(halt_mem), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en),
        .em_en(em_en), .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush),
        .em_flush(em_flush), .halt(halt), .stall_count(stall_count)
    );

    pipeline_controller #(.CNTW(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .hazard_dec(hazard_dec), .hazard_ex(hazard_ex), .branch_ex(branch_ex),
        .halt_mem(halt_mem), .pc_en(pc_en2), .fd_en(fd_en2), .de_en(de_en2),
        .em_en(em_en2), .mw_en(mw_en2), .fd_flush(fdf2), .de_flush(def2),
        .em_flush(emf2), .halt(halt2), .stall_count(stall_sat)
    );

    typedef struct {
        string       tag;
        logic [7:0]  ctl;   // {pc,fd,de,em,mw,fd_flush,de_flush,em_flush}
        logic        hlt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Control vectors
    localparam logic [7:0] NORM = 8'b11111_000;
    localparam logic [7:0] BUB  = 8'b00111_010;
    localparam logic [7:0] BRF  = 8'b11111_110;
    localparam logic [7:0] HLT  = 8'b01111_111;
    localparam logic [7:0] DRN  = 8'b00001_000;
    localparam logic [7:0] IDLE = 8'b00000_000;
    localparam logic [7:0] RET  = 8'b00011_001;

    // Inputs {ihit,dhit,mem_req,hazard_dec,hazard_ex,branch_ex,halt_mem}
    localparam logic [6:0] I_RUN  = 7'b1000000;
    localparam logic [6:0] I_HD   = 7'b1001000;
    localparam logic [6:0] I_HE   = 7'b1000100;
    localparam logic [6:0] I_HDE  = 7'b1001100;
    localparam logic [6:0] I_BR   = 7'b1000010;
    localparam logic [6:0] I_HM   = 7'b1000001;
    localparam logic [6:0] I_NOI  = 7'b0000000;
    localparam logic [6:0] I_MWT  = 7'b1010000;
    localparam logic [6:0] I_DHIT = 7'b0110000;

    task automatic expect_push(input string tag, input logic [7:0] ctl,
                               input logic hlt, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.hlt = hlt; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [7:0] obs;
        logic [1:0] sat_exp;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        obs = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush};
        sat_exp = (e.cnt > 32'd3) ? 2'd3 : e.cnt[1:0];
        vectors++;
        assert (obs === e.ctl) else begin
            miscompares++;
            $error("FAIL %s_ctl observed=%b expected=%b", e.tag, obs, e.ctl);
        end
        vectors++;
        assert (halt === e.hlt) else begin
            miscompares++;
            $error("FAIL %s_halt observed=%b expected=%b", e.tag, halt, e.hlt);
        end
        vectors++;
        assert (stall_count === e.cnt) else begin
            miscompares++;
            $error("FAIL %s_cnt observed=%0d expected=%0d", e.tag, stall_count, e.cnt);
        end
        vectors++;
        assert (stall_sat === sat_exp) else begin
            miscompares++;
            $error("FAIL %s_sat observed=%0d expected=%0d", e.tag, stall_sat, sat_exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, check at falling edge.
    task automatic cyc(input string tag, input logic [6:0] in, input logic [7:0] ctl,
                       input logic hlt, input logic [31:0] cnt);
        @(posedge CLK);
        #1;
        {ihit, dhit, mem_req, hazard_dec, hazard_ex, branch_ex, halt_mem} = in;
        expect_push(tag, ctl, hlt, cnt);
        @(negedge CLK);
        check_pop();
    endtask

    initial begin
        nRST = 1'b0;
        {ihit, dhit, mem_req, hazard_dec, hazard_ex, branch_ex, halt_mem} = I_RUN;

        // Reset held with ihit=1: everything quiet
        expect_push("reset", IDLE, 1'b0, 32'd0);
        @(negedge CLK);
        check_pop();
        expect_push("reset2", IDLE, 1'b0, 32'd0);
        @(negedge CLK);
        check_pop();

        @(posedge CLK);
        #1 nRST = 1'b1;
        expect_push("post_reset", NORM, 1'b0, 32'd0);
        @(negedge CLK);
        check_pop();

        cyc("run0",   I_RUN, NORM, 1'b0, 32'd0);
        // hazard_dec: two bubbles
        cyc("hd_b1",  I_HD,  BUB,  1'b0, 32'd0);
        cyc("hd_b2",  I_RUN, BUB,  1'b0, 32'd1);
        cyc("hd_end", I_RUN, NORM, 1'b0, 32'd2);
        // hazard_ex then 3 fetch-wait cycles: one bubble only
        cyc("he_b1",  I_HE,  BUB,  1'b0, 32'd2);
        cyc("he_w1",  I_NOI, IDLE, 1'b0, 32'd3);
        cyc("he_w2",  I_NOI, IDLE, 1'b0, 32'd4);
        cyc("he_w3",  I_NOI, IDLE, 1'b0, 32'd5);
        cyc("he_end", I_RUN, NORM, 1'b0, 32'd6);
        // hazard_dec then gap: second bubble after the gap
        cyc("hdg_b1", I_HD,  BUB,  1'b0, 32'd6);
        cyc("hdg_w1", I_NOI, IDLE, 1'b0, 32'd7);
        cyc("hdg_w2", I_NOI, IDLE, 1'b0, 32'd8);
        cyc("hdg_w3", I_NOI, IDLE, 1'b0, 32'd9);
        cyc("hdg_b2", I_RUN, BUB,  1'b0, 32'd10);
        cyc("hdg_end",I_RUN, NORM, 1'b0, 32'd11);
        // Data-memory wait, then dhit without ihit
        for (int k = 0; k < 4; k++)
            cyc("mem_wait", I_MWT, IDLE, 1'b0, 32'd11 + 32'(k));
        cyc("mem_ret", I_DHIT, RET,  1'b0, 32'd15);
        cyc("mem_end", I_RUN,  NORM, 1'b0, 32'd16);
        // Branch cancels pending bubble
        cyc("br_b1",  I_HD,  BUB,  1'b0, 32'd16);
        cyc("br_sq",  I_BR,  BRF,  1'b0, 32'd17);
        cyc("br_end", I_RUN, NORM, 1'b0, 32'd17);
        // Both hazards: hazard_dec wins
        cyc("both_b1",I_HDE, BUB,  1'b0, 32'd17);
        cyc("both_b2",I_RUN, BUB,  1'b0, 32'd18);
        cyc("both_end",I_RUN,NORM, 1'b0, 32'd19);
        // Halt: N, drain N+1, halted from N+2
        cyc("halt_n",  I_HM,  HLT,  1'b0, 32'd19);
        cyc("drain",   I_RUN, DRN,  1'b0, 32'd20);
        cyc("halted2", I_RUN, IDLE, 1'b1, 32'd20);
        cyc("halted3", I_HM,  IDLE, 1'b1, 32'd20);
        cyc("halted4", I_BR,  IDLE, 1'b1, 32'd20);

        // Asynchronous reset mid-cycle at N+5
        @(posedge CLK);
        #1 {ihit, dhit, mem_req, hazard_dec, hazard_ex, branch_ex, halt_mem} = I_RUN;
        #1 nRST = 1'b0;
        expect_push("async_rst", IDLE, 1'b0, 32'd0);
        #1 check_pop();
        @(posedge CLK);
        #1 nRST = 1'b1;
        expect_push("rerun", NORM, 1'b0, 32'd0);
        @(negedge CLK);
        check_pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencing controller for the pipelined MIPS datapath. It sits between the hazard unit, the cache hit signals and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC. Each cycle it decides which latches advance, hold or flush. It also counts load-use bubbles across cycles, drains the pipeline on halt, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- CNTW, 32, width of the stall-cycle counter (matches `word_t`).

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  system clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch completes this cycle.
- dhit  input  1  data access of the MEM-stage instruction completes this cycle.
- mem_req  input  1  MEM-stage instruction reads or writes data memory.
- hazard_dec  input  1  hazard unit flag: the decode instruction needs 2 bubbles (producer load in EX, no MEM forward).
- hazard_ex  input  1  hazard unit flag: the decode instruction needs 1 bubble.
- branch_ex  input  1  EX-stage branch or jump is taken (PC target valid).
- halt_mem  input  1  a halt instruction is in the MEM stage.
- pc_en  output  1  PC load enable.
- fd_en, de_en, em_en, mw_en  output  1 each  latch enables.
- fd_flush, de_flush, em_flush  output  1 each  synchronous latch clears (bubble insert); a flush is valid only together with that latch's enable.
- halt  output  1  processor halted (sticky).
- stall_count  output  CNTW  cycles in RUN with pc_en low.

## Operation
- advance = ihit & !(mem_req & !dhit).
- Registered state: fsm ∈ {RUN, DRAIN, HALTED}, bub_cnt[1:0], stall_count.
- Enables and flushes are combinational from the state and the current inputs. All of them are 0 while nRST is low.
- RUN, evaluated in this priority order:
  1. !advance: all enables and flushes are 0, except when dhit & !ihit. In that case mw_en=1, em_en=1 and em_flush=1: the finished memory op retires, and EX/MEM is cleared so the access does not re-issue.
  2. advance & halt_mem: pc_en=0; fd_en, de_en, em_en and mw_en are 1; fd_flush, de_flush and em_flush are 1. Next state DRAIN; bub_cnt←0.
  3. advance & branch_ex: all enables are 1; fd_flush=1 and de_flush=1. bub_cnt←0. Flushing the wrong-path instruction takes priority over any pending bubble.
  4. advance & (bub_cnt≠0 | hazard_dec | hazard_ex): pc_en=0, fd_en=0, de_en=1, de_flush=1, em_en=1, mw_en=1.
     - If bub_cnt≠0: bub_cnt decrements and the hazard inputs are ignored.
     - Otherwise hazard_dec loads bub_cnt←1 (2 bubbles total), and hazard_ex alone loads bub_cnt←0 (1 bubble total). When both are set, hazard_dec wins.
  5. advance otherwise: all enables are 1 and no flushes.
- bub_cnt only changes on advance cycles. It holds through memory or fetch waits.
- DRAIN: mw_en=1, all other enables 0. Unconditionally next state HALTED.
- HALTED: all enables and flushes are 0, halt=1. Only nRST leaves this state.
- stall_count: increments by 1 on each RUN cycle with pc_en=0, and saturates at all-ones (no wrap). It holds in DRAIN and HALTED.

## Timing
- Reset values: fsm=RUN, bub_cnt=0, stall_count=0, halt=0, all enables and flushes 0.
- Reset is asynchronous: asserting nRST mid-stall or mid-drain clears everything immediately.
- Zero-latency control: an enable reflects same-cycle inputs. State, bub_cnt and stall_count update on the CLK edge.
- Latency to halt: halt_mem with advance at cycle N gives DRAIN at N+1 and halt=1 from N+2.
- A load-use stall with no waits costs exactly 1 bubble (hazard_ex) or 2 bubbles (hazard_dec) into ID/EX.
- branch_ex during a pending bubble cancels the remaining bubbles in the same cycle.

## Test plan
- Reset with ihit=1 held: all enables are 0 while nRST=0. On the first cycle after release, all enables are 1, and halt=0 and stall_count=0.
- hazard_dec pulse for 1 cycle with ihit=1: pc_en=0 and de_flush=1 for exactly 2 consecutive cycles, then normal. stall_count=2.
- hazard_ex, then ihit=0 for 3 cycles, then ihit=1:
  - with hazard_ex: 1 bubble only.
  - with hazard_dec: the second bubble lands on the first ihit after the gap. bub_cnt holds across the gap.
  - stall_count covers both the bubble cycles and the ihit=0 cycles.
- mem_req=1, dhit=0 for 4 cycles, then dhit=1 with ihit=0: all enables are 0 during the wait. In the dhit cycle mw_en=1, em_en=1, em_flush=1 and pc_en=0.
- hazard_dec, then on the next cycle branch_ex=1: fd_flush=1, de_flush=1 and pc_en=1 in the branch cycle. No further bubble follows.
- halt_mem at cycle N with advance: DRAIN at N+1 with mw_en=1 only, and halt=1 from N+2 onward. When nRST is asserted at N+5, halt→0 immediately and stall_count→0.
